// File: rtl/vortex_axi_mem_responder.sv
// AXI4 slave memory responder for the Vortex AXI master port.
// Holds MEM_DEPTH words of DATA_WIDTH bits and serves INCR read and write
// bursts (one outstanding burst per direction) with ID, last and response
// signalling. Unsupported bursts answer SLVERR without touching memory.
//
// Handshake rule: a beat transfers on the rising clk edge where valid and
// ready are both high. A source never drops valid, and never changes its
// payload, until that transfer happens.
module vortex_axi_mem_responder #(
    parameter int ID_WIDTH   = 32,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 512,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    // write address
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [ID_WIDTH-1:0]     s_axi_awid,
    input  logic [7:0]              s_axi_awlen,
    input  logic [2:0]              s_axi_awsize,
    input  logic [1:0]              s_axi_awburst,
    // write data
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wlast,
    // write response
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    output logic [ID_WIDTH-1:0]     s_axi_bid,
    output logic [1:0]              s_axi_bresp,
    // read address
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [ID_WIDTH-1:0]     s_axi_arid,
    input  logic [7:0]              s_axi_arlen,
    input  logic [2:0]              s_axi_arsize,
    input  logic [1:0]              s_axi_arburst,
    // read data
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic                    s_axi_rlast,
    output logic [ID_WIDTH-1:0]     s_axi_rid,
    output logic [1:0]              s_axi_rresp,
    // FSM state visibility
    output logic [1:0]              dbg_w_state,
    output logic                    dbg_r_state
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int LSB    = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(MEM_DEPTH);
    localparam int HI     = LSB + IDX_W;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    w_state_t w_state, w_state_nxt;
    r_state_t r_state, r_state_nxt;

    // captured write burst
    logic [ID_WIDTH-1:0] w_id;
    logic [7:0]          w_len, w_cnt;
    logic [IDX_W-1:0]    w_idx;
    logic                w_err;   // burst-wide: blocks memory writes
    logic                w_lerr;  // wlast misplaced: response only

    // captured read burst
    logic [ID_WIDTH-1:0]   r_id;
    logic [7:0]            r_len, r_cnt;
    logic [IDX_W-1:0]      r_idx;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_data;

    logic             aw_fire, w_fire, ar_fire, r_fire;
    logic             aw_err, ar_err;
    logic [IDX_W-1:0] aw_idx, ar_idx;
    logic             r_last_beat;

    // byte-offset bits below the word index play no part in addressing
    logic unused_addr_bits;
    assign unused_addr_bits = ^{s_axi_awaddr[LSB-1:0], s_axi_araddr[LSB-1:0]};

    assign aw_idx = s_axi_awaddr[LSB +: IDX_W];
    assign ar_idx = s_axi_araddr[LSB +: IDX_W];
    assign aw_err = (s_axi_awburst != BURST_INCR) || (s_axi_awsize != 3'(LSB))
                    || (|s_axi_awaddr[ADDR_WIDTH-1:HI]);
    assign ar_err = (s_axi_arburst != BURST_INCR) || (s_axi_arsize != 3'(LSB))
                    || (|s_axi_araddr[ADDR_WIDTH-1:HI]);

    assign aw_fire     = s_axi_awvalid && s_axi_awready;
    assign w_fire      = s_axi_wvalid && s_axi_wready;
    assign ar_fire     = s_axi_arvalid && s_axi_arready;
    assign r_fire      = s_axi_rvalid && s_axi_rready;
    assign r_last_beat = (r_cnt == r_len);

    assign s_axi_bid   = w_id;
    assign s_axi_bresp = (w_err || w_lerr) ? RESP_SLVERR : RESP_OKAY;
    assign s_axi_rid   = r_id;
    assign s_axi_rresp = r_err ? RESP_SLVERR : RESP_OKAY;
    assign s_axi_rdata = r_data;

    assign dbg_w_state = w_state;
    assign dbg_r_state = r_state;

    // ---------------- write side ----------------

    // write FSM state register
    always_ff @(posedge clk) begin
        if (rst) w_state <= W_IDLE;
        else     w_state <= w_state_nxt;
    end

    // write FSM next state and handshake outputs
    always_comb begin
        w_state_nxt   = w_state;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        unique case (w_state)
            W_IDLE: begin
                s_axi_awready = 1'b1;
                if (s_axi_awvalid) w_state_nxt = W_DATA;
            end
            W_DATA: begin
                s_axi_wready = 1'b1;
                if (s_axi_wvalid && (w_cnt == w_len)) w_state_nxt = W_RESP;
            end
            W_RESP: begin
                s_axi_bvalid = 1'b1;
                if (s_axi_bready) w_state_nxt = W_IDLE;
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    // capture the write burst and track beats; the counter alone ends it
    always_ff @(posedge clk) begin
        if (rst) begin
            w_id   <= '0;
            w_len  <= '0;
            w_cnt  <= '0;
            w_idx  <= '0;
            w_err  <= 1'b0;
            w_lerr <= 1'b0;
        end else if (aw_fire) begin
            w_id   <= s_axi_awid;
            w_len  <= s_axi_awlen;
            w_cnt  <= '0;
            w_idx  <= aw_idx;
            w_err  <= aw_err;
            w_lerr <= 1'b0;
        end else if (w_fire) begin
            w_cnt <= w_cnt + 8'd1;
            w_idx <= w_idx + IDX_W'(1);
            if (s_axi_wlast != (w_cnt == w_len)) w_lerr <= 1'b1;
        end
    end

    // byte-masked memory write; contents survive reset
    always_ff @(posedge clk) begin
        if (w_fire && !w_err) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (s_axi_wstrb[b]) mem[w_idx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
            end
        end
    end

    // ---------------- read side ----------------

    // read FSM state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= R_IDLE;
        else     r_state <= r_state_nxt;
    end

    // read FSM next state and handshake outputs
    always_comb begin
        r_state_nxt   = r_state;
        s_axi_arready = 1'b0;
        s_axi_rvalid  = 1'b0;
        s_axi_rlast   = 1'b0;
        unique case (r_state)
            R_IDLE: begin
                s_axi_arready = 1'b1;
                if (s_axi_arvalid) r_state_nxt = R_DATA;
            end
            R_DATA: begin
                s_axi_rvalid = 1'b1;
                s_axi_rlast  = r_last_beat;
                if (s_axi_rready && r_last_beat) r_state_nxt = R_IDLE;
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    // capture the read burst and advance the beat pointer on each transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_id  <= '0;
            r_len <= '0;
            r_cnt <= '0;
            r_idx <= '0;
            r_err <= 1'b0;
        end else if (ar_fire) begin
            r_id  <= s_axi_arid;
            r_len <= s_axi_arlen;
            r_cnt <= '0;
            r_idx <= ar_idx;
            r_err <= ar_err;
        end else if (r_fire && !r_last_beat) begin
            r_cnt <= r_cnt + 8'd1;
            r_idx <= r_idx + IDX_W'(1);
        end
    end

    // registered read data: the beat is fetched the cycle before it is
    // presented, so a same-cycle write to that word is not seen (read-first)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
        end else if (ar_fire) begin
            r_data <= ar_err ? '0 : mem[ar_idx];
        end else if (r_fire && !r_last_beat) begin
            r_data <= r_err ? '0 : mem[r_idx + IDX_W'(1)];
        end
    end

endmodule

// File: tb/tb_vortex_axi_mem_responder.sv
// Randomized scoreboard bench for vortex_axi_mem_responder: drivers push the
// expected B/R responses from a flat-array memory model, monitors pop them.
module tb_vortex_axi_mem_responder;

    localparam int IW    = 32;
    localparam int AW    = 64;
    localparam int DW    = 512;
    localparam int DEPTH = 1024;
    localparam int SW    = DW / 8;
    localparam int LSB   = 6;
    localparam int IDXW  = 10;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic [IW-1:0] id;
        logic [1:0]    resp;
    } r_exp_t;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [1:0]    resp;
    } b_exp_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          awvalid = 0, awready;
    logic [AW-1:0] awaddr = '0;
    logic [IW-1:0] awid = '0;
    logic [7:0]    awlen = '0;
    logic [2:0]    awsize = '0;
    logic [1:0]    awburst = '0;
    logic          wvalid = 0, wready;
    logic [DW-1:0] wdata = '0;
    logic [SW-1:0] wstrb = '0;
    logic          wlast = 0;
    logic          bvalid, bready = 0;
    logic [IW-1:0] bid;
    logic [1:0]    bresp;
    logic          arvalid = 0, arready;
    logic [AW-1:0] araddr = '0;
    logic [IW-1:0] arid = '0;
    logic [7:0]    arlen = '0;
    logic [2:0]    arsize = '0;
    logic [1:0]    arburst = '0;
    logic          rvalid, rready = 0;
    logic [DW-1:0] rdata;
    logic          rlast;
    logic [IW-1:0] rid;
    logic [1:0]    rresp;
    logic [1:0]    dbg_w_state;
    logic          dbg_r_state;

    vortex_axi_mem_responder #(
        .ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axi_awvalid(awvalid), .s_axi_awready(awready), .s_axi_awaddr(awaddr),
        .s_axi_awid(awid), .s_axi_awlen(awlen), .s_axi_awsize(awsize), .s_axi_awburst(awburst),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_wdata(wdata),
        .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
        .s_axi_bvalid(bvalid), .s_axi_bready(bready), .s_axi_bid(bid), .s_axi_bresp(bresp),
        .s_axi_arvalid(arvalid), .s_axi_arready(arready), .s_axi_araddr(araddr),
        .s_axi_arid(arid), .s_axi_arlen(arlen), .s_axi_arsize(arsize), .s_axi_arburst(arburst),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready), .s_axi_rdata(rdata),
        .s_axi_rlast(rlast), .s_axi_rid(rid), .s_axi_rresp(rresp),
        .dbg_w_state(dbg_w_state), .dbg_r_state(dbg_r_state)
    );

    // ---------------- model and scoreboard state ----------------
    logic [DW-1:0] model_mem [DEPTH];
    r_exp_t        exp_r_q[$];
    b_exp_t        exp_b_q[$];
    int            n_cmp  = 0;
    int            n_fail = 0;

    logic [DW-1:0] wr_data [256];
    logic [SW-1:0] wr_strb [256];
    logic          wr_last [256];

    int   r_mode = 0;     // 0: rready always 1, 1: toggle, 2: random
    logic r_hold = 1'b0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: got timeout expected handshake", name);
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    function automatic logic burst_err(input logic [AW-1:0] addr, input logic [1:0] burst,
                                       input logic [2:0] size);
        return (burst != 2'b01) || (size != 3'(LSB)) || ((addr >> (LSB + IDXW)) != 0);
    endfunction

    function automatic int word_of(input logic [AW-1:0] addr);
        return int'((addr >> LSB) % DEPTH);
    endfunction

    // ---------------- ready generators ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (r_hold)           rready = 1'b0;
            else if (r_mode == 0) rready = 1'b1;
            else if (r_mode == 1) rready = ~rready;
            else                  rready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            bready = ($urandom_range(0, 2) != 0);
        end
    end

    // ---------------- monitors ----------------
    r_exp_t mon_r;
    b_exp_t mon_b;

    always @(negedge clk) begin
        if (!rst) begin
            if (rvalid) begin
                if (exp_r_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL r_unexpected: got beat rid=%0h expected none", rid);
                end else begin
                    mon_r = exp_r_q[0];
                    check("rdata", rdata, mon_r.data);
                    check("rlast", DW'(rlast), DW'(mon_r.last));
                    check("rid", DW'(rid), DW'(mon_r.id));
                    check("rresp", DW'(rresp), DW'(mon_r.resp));
                    if (rready) void'(exp_r_q.pop_front());
                end
            end
            if (bvalid) begin
                if (exp_b_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL b_unexpected: got bid=%0h expected none", bid);
                end else begin
                    mon_b = exp_b_q[0];
                    check("bid", DW'(bid), DW'(mon_b.id));
                    check("bresp", DW'(bresp), DW'(mon_b.resp));
                    if (bready) void'(exp_b_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic fill_wr(input int len);
        for (int i = 0; i <= len; i++) begin
            wr_data[i] = rand_word();
            wr_strb[i] = '1;
            wr_last[i] = (i == len);
        end
    endtask

    task automatic aw_send(input logic [AW-1:0] addr, input logic [IW-1:0] id, input int len,
                           input logic [1:0] burst, input logic [2:0] size);
        int n = 0;
        awaddr = addr; awid = id; awlen = 8'(len); awburst = burst; awsize = size;
        awvalid = 1'b1;
        @(negedge clk);
        while (!awready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!awready) timeout("aw_handshake");
        @(posedge clk);
        #1;
        awvalid = 1'b0;
    endtask

    task automatic ar_send(input logic [AW-1:0] addr, input logic [IW-1:0] id, input int len,
                           input logic [1:0] burst, input logic [2:0] size);
        int n = 0;
        araddr = addr; arid = id; arlen = 8'(len); arburst = burst; arsize = size;
        arvalid = 1'b1;
        @(negedge clk);
        while (!arready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!arready) timeout("ar_handshake");
        @(posedge clk);
        #1;
        arvalid = 1'b0;
    endtask

    task automatic wait_b_drained();
        int n = 0;
        @(posedge clk);
        while (exp_b_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (exp_b_q.size() != 0) begin
            timeout("b_response");
            exp_b_q.delete();
        end
        #1;
    endtask

    task automatic wait_r_drained();
        int n = 0;
        @(posedge clk);
        while (exp_r_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        if (exp_r_q.size() != 0) begin
            timeout("r_beats");
            exp_r_q.delete();
        end
        #1;
    endtask

    // Write burst using wr_data/wr_strb/wr_last; model updated up front.
    task automatic write_burst(input logic [AW-1:0] addr, input logic [IW-1:0] id, input int len,
                               input logic [1:0] burst, input logic [2:0] size);
        logic   err, lerr;
        int     base, n;
        b_exp_t be;
        err  = burst_err(addr, burst, size);
        base = word_of(addr);
        lerr = 1'b0;
        for (int i = 0; i <= len; i++) begin
            if (wr_last[i] != (i == len)) lerr = 1'b1;
            if (!err) begin
                for (int b = 0; b < SW; b++)
                    if (wr_strb[i][b]) model_mem[(base + i) % DEPTH][b*8 +: 8] = wr_data[i][b*8 +: 8];
            end
        end
        be.id   = id;
        be.resp = (err || lerr) ? 2'b10 : 2'b00;
        exp_b_q.push_back(be);
        aw_send(addr, id, len, burst, size);
        for (int i = 0; i <= len; i++) begin
            repeat ($urandom_range(0, 1)) begin
                @(posedge clk);
                #1;
            end
            wdata = wr_data[i]; wstrb = wr_strb[i]; wlast = wr_last[i];
            wvalid = 1'b1;
            n = 0;
            @(negedge clk);
            while (!wready && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (!wready) timeout("w_beat");
            @(posedge clk);
            #1;
            wvalid = 1'b0;
        end
        @(negedge clk);
        check("wready_after_last_beat", DW'(wready), DW'(0));
        wait_b_drained();
    endtask

    task automatic push_read_exp(input logic [AW-1:0] addr, input logic [IW-1:0] id, input int len,
                                 input logic [1:0] burst, input logic [2:0] size);
        logic   err;
        int     base;
        r_exp_t re;
        err  = burst_err(addr, burst, size);
        base = word_of(addr);
        for (int i = 0; i <= len; i++) begin
            re.data = err ? '0 : model_mem[(base + i) % DEPTH];
            re.last = (i == len);
            re.id   = id;
            re.resp = err ? 2'b10 : 2'b00;
            exp_r_q.push_back(re);
        end
    endtask

    task automatic read_burst(input logic [AW-1:0] addr, input logic [IW-1:0] id, input int len,
                              input logic [1:0] burst, input logic [2:0] size);
        push_read_exp(addr, id, len, burst, size);
        ar_send(addr, id, len, burst, size);
        @(negedge clk);
        check("rvalid_at_t_plus_1", DW'(rvalid), DW'(1));
        wait_r_drained();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int            idx, len, flavor;
        logic [AW-1:0] addr;
        logic [1:0]    burst;
        logic [2:0]    size;
        r_exp_t        re;
        b_exp_t        be;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_awready", DW'(awready), DW'(1));
        check("rst_arready", DW'(arready), DW'(1));
        check("rst_wready", DW'(wready), DW'(0));
        check("rst_bvalid", DW'(bvalid), DW'(0));
        check("rst_rvalid", DW'(rvalid), DW'(0));
        check("rst_rlast", DW'(rlast), DW'(0));
        check("rst_bresp", DW'(bresp), DW'(0));
        check("rst_rresp", DW'(rresp), DW'(0));
        check("rst_bid", DW'(bid), DW'(0));
        check("rst_rid", DW'(rid), DW'(0));
        check("rst_rdata", rdata, DW'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // fill the whole memory so every later read has a known value
        for (int k = 0; k < DEPTH / 256; k++) begin
            fill_wr(255);
            write_burst(AW'(k * 256) << LSB, IW'(k), 255, 2'b01, 3'(LSB));
        end

        // single beat write then read
        for (int b = 0; b < SW; b++) wr_data[0][b*8 +: 8] = 8'hA5;
        wr_strb[0] = '1; wr_last[0] = 1'b1;
        write_burst(64'h40, 32'd7, 0, 2'b01, 3'(LSB));
        read_burst(64'h40, 32'd3, 0, 2'b01, 3'(LSB));

        // 4-beat write with a single-byte strobe on beat 2, read with rready toggling
        fill_wr(3);
        for (int i = 0; i < 4; i++) wr_data[i] = DW'(i + 1);
        wr_strb[2] = SW'(1);
        write_burst(64'h0, 32'd11, 3, 2'b01, 3'(LSB));
        r_mode = 1;
        read_burst(64'h0, 32'd12, 3, 2'b01, 3'(LSB));
        r_mode = 0;

        // FIXED burst: beats accepted, SLVERR, memory untouched
        fill_wr(1);
        write_burst(64'h800, 32'd21, 1, 2'b00, 3'(LSB));
        read_burst(64'h800, 32'd22, 1, 2'b01, 3'(LSB));
        // address above the index field
        read_burst(64'h1 << 40, 32'd23, 1, 2'b01, 3'(LSB));

        // early wlast: all three beats still land, SLVERR
        fill_wr(2);
        wr_last[0] = 1'b1; wr_last[2] = 1'b1;
        write_burst(64'h1000, 32'd31, 2, 2'b01, 3'(LSB));
        read_burst(64'h1000, 32'd32, 2, 2'b01, 3'(LSB));

        // same-cycle read and write beat to one word: read sees the old value
        idx = 100;
        re.data = model_mem[idx]; re.last = 1'b1; re.id = 32'd41; re.resp = 2'b00;
        exp_r_q.push_back(re);
        be.id = 32'd42; be.resp = 2'b00;
        exp_b_q.push_back(be);
        wr_data[0] = rand_word();
        model_mem[idx] = wr_data[0];
        aw_send(AW'(idx) << LSB, 32'd42, 0, 2'b01, 3'(LSB));
        wdata = wr_data[0]; wstrb = '1; wlast = 1'b1; wvalid = 1'b1;
        araddr = AW'(idx) << LSB; arid = 32'd41; arlen = 8'd0; arburst = 2'b01;
        arsize = 3'(LSB); arvalid = 1'b1;
        @(negedge clk);
        check("same_cycle_wready", DW'(wready), DW'(1));
        check("same_cycle_arready", DW'(arready), DW'(1));
        @(posedge clk);
        #1;
        wvalid = 1'b0; arvalid = 1'b0;
        wait_r_drained();
        wait_b_drained();
        read_burst(AW'(idx) << LSB, 32'd43, 0, 2'b01, 3'(LSB));

        // index wrap at the top of memory
        read_burst(AW'(DEPTH - 1) << LSB, 32'd51, 1, 2'b01, 3'(LSB));

        // reset in the middle of an 8-beat read
        push_read_exp(64'h2000, 32'd61, 7, 2'b01, 3'(LSB));
        ar_send(64'h2000, 32'd61, 7, 2'b01, 3'(LSB));
        repeat (3) @(negedge clk);
        r_hold = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        exp_r_q.delete();
        @(negedge clk);
        check("mid_rst_rvalid", DW'(rvalid), DW'(0));
        check("mid_rst_arready", DW'(arready), DW'(1));
        check("mid_rst_rlast", DW'(rlast), DW'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        r_hold = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        read_burst(64'h2000, 32'd62, 1, 2'b01, 3'(LSB));

        // randomized mix
        r_mode = 2;
        for (int t = 0; t < 40; t++) begin
            idx    = $urandom_range(0, DEPTH - 1);
            len    = $urandom_range(0, 15);
            addr   = AW'(idx) << LSB;
            burst  = 2'b01;
            size   = 3'(LSB);
            flavor = $urandom_range(0, 9);
            if (flavor == 0) burst = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b10;
            if (flavor == 1) size = 3'(LSB - 1);
            if (flavor == 2) addr = addr | (AW'(1) << (LSB + IDXW + $urandom_range(0, 20)));
            if ($urandom_range(0, 1) == 0) begin
                fill_wr(len);
                for (int i = 0; i <= len; i++)
                    for (int b = 0; b < SW; b++) wr_strb[i][b] = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 7) == 0) begin
                    int j = $urandom_range(0, len);
                    wr_last[j] = ~wr_last[j];
                end
                write_burst(addr, $urandom, len, burst, size);
            end else begin
                read_burst(addr, $urandom, len, burst, size);
            end
        end

        repeat (5) @(posedge clk);
        check("r_queue_drained", DW'(exp_r_q.size()), DW'(0));
        check("b_queue_drained", DW'(exp_b_q.size()), DW'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // global time bound
    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
